// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-sprite generator: FSM states,
// colour constants and the debug view of the sprite state.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_HIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb_t;

    localparam rgb_t COLOR_OFF = {10'd0,    10'd0,    10'd0};
    localparam rgb_t COLOR_BOX = {10'd1023, 10'd1023, 10'd0};
    localparam rgb_t COLOR_HIT = {10'd1023, 10'd0,    10'd0};
    localparam rgb_t COLOR_BG  = {10'd0,    10'd0,    10'd512};

    // Width of the hit-flash frame counter (FLASH_FRAMES up to 256).
    localparam int FLASH_W = 8;

    // Snapshot of the internal sprite state for observation.
    // dir_x/dir_y: 0 = moving right/down, 1 = moving left/up.
    typedef struct packed {
        state_t             state;
        logic [9:0]         pos_x;
        logic [9:0]         pos_y;
        logic               dir_x;
        logic               dir_y;
        logic [FLASH_W-1:0] flash_cnt;
    } dbg_t;

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: position register, direction flag and the
// move-and-bounce rule. Position only changes when step_en is high.
module sprite_axis #(
    parameter int LIMIT    = 640,
    parameter int BOX_SIZE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    input  logic [3:0] speed,
    output logic [9:0] pos,
    output logic       dir_back,
    output logic       bounce
);

    // Largest legal top-left coordinate on this axis.
    localparam logic [10:0] EDGE = 11'(LIMIT - BOX_SIZE);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [10:0] pos_w, spd_w, fwd_w;

    // Arithmetic is done at 11 bits so a forward step can never wrap.
    assign pos_w = {1'b0, pos_q};
    assign spd_w = {7'b0, speed};
    assign fwd_w = pos_w + spd_w;

    // Next position/direction: step, clamp at the walls and reverse.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        bounce = 1'b0;
        if (step_en) begin
            if (!dir_q) begin
                if (fwd_w >= EDGE) begin
                    pos_d  = EDGE[9:0];
                    dir_d  = 1'b1;
                    bounce = 1'b1;
                end else begin
                    pos_d = fwd_w[9:0];
                end
            end else begin
                if (pos_w < spd_w) begin
                    pos_d  = 10'd0;
                    dir_d  = 1'b0;
                    bounce = 1'b1;
                end else begin
                    pos_d = pos_q - {6'b0, speed};
                end
            end
        end
    end

    // Position and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= 10'd0;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos      = pos_q;
    assign dir_back = dir_q;

endmodule

// File: rtl/vga_sprite_gen.sv
// Bouncing square sprite for a VGA controller. The box moves once per
// frame (at the last visible pixel) so it is never torn, flashes the hit
// colour for FLASH_FRAMES frames after a wall bounce and counts bounces.
module vga_sprite_gen
    import vga_pkg::*;
#(
    parameter int BOX_SIZE     = 32,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    input  logic       iImValid,
    input  logic       iRun,
    input  logic [3:0] iSpeed,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic [7:0] oBounceCnt,
    output dbg_t       oDbg
);

    state_t             state_q, state_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic [7:0]         cnt_q, cnt_d;
    rgb_t               rgb_q, rgb_d;

    logic       frame_tick, move_en, any_bounce;
    logic [9:0] pos_x, pos_y;
    logic       dir_x, dir_y, bounce_x, bounce_y;
    logic       in_box;

    assign frame_tick = iImValid && (iX == 10'(H_ACTIVE - 1)) && (iY == 10'(V_ACTIVE - 1));
    assign move_en    = frame_tick && (state_q == ST_RUN || state_q == ST_HIT);
    assign any_bounce = bounce_x || bounce_y;

    sprite_axis #(.LIMIT(H_ACTIVE), .BOX_SIZE(BOX_SIZE)) u_axis_x (
        .clk      (iClk),
        .rst      (iRst),
        .step_en  (move_en),
        .speed    (iSpeed),
        .pos      (pos_x),
        .dir_back (dir_x),
        .bounce   (bounce_x)
    );

    sprite_axis #(.LIMIT(V_ACTIVE), .BOX_SIZE(BOX_SIZE)) u_axis_y (
        .clk      (iClk),
        .rst      (iRst),
        .step_en  (move_en),
        .speed    (iSpeed),
        .pos      (pos_y),
        .dir_back (dir_y),
        .bounce   (bounce_y)
    );

    // Next state and flash counter; iRun low always wins immediately.
    always_comb begin
        state_d = state_q;
        flash_d = flash_q;
        case (state_q)
            ST_PAUSE: begin
                if (iRun) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!iRun) begin
                    state_d = ST_PAUSE;
                end else if (move_en && any_bounce) begin
                    state_d = ST_HIT;
                    flash_d = FLASH_W'(FLASH_FRAMES - 1);
                end
            end
            ST_HIT: begin
                if (!iRun) begin
                    state_d = ST_PAUSE;
                end else if (frame_tick) begin
                    if (any_bounce) begin
                        flash_d = FLASH_W'(FLASH_FRAMES - 1);
                    end else if (flash_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        flash_d = flash_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    // State and flash counter registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_PAUSE;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
        end
    end

    // Bounce counter: one increment per frame tick with any wall hit.
    always_comb begin
        cnt_d = cnt_q;
        if (move_en && any_bounce) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge iClk) begin
        if (iRst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
    end

    // Pixel colour: box/hit colour inside the sprite, background elsewhere.
    assign in_box = ({1'b0, iX} >= {1'b0, pos_x}) &&
                    ({1'b0, iX} <  {1'b0, pos_x} + 11'(BOX_SIZE)) &&
                    ({1'b0, iY} >= {1'b0, pos_y}) &&
                    ({1'b0, iY} <  {1'b0, pos_y} + 11'(BOX_SIZE));

    always_comb begin
        rgb_d = COLOR_BG;
        if (!iImValid)               rgb_d = COLOR_OFF;
        else if (in_box && state_q == ST_HIT) rgb_d = COLOR_HIT;
        else if (in_box)             rgb_d = COLOR_BOX;
    end

    // Registered colour output, one cycle behind the pixel coordinates.
    always_ff @(posedge iClk) begin
        if (iRst) rgb_q <= COLOR_OFF;
        else      rgb_q <= rgb_d;
    end

    assign oRed       = rgb_q.r;
    assign oGreen     = rgb_q.g;
    assign oBlue      = rgb_q.b;
    assign oBounceCnt = cnt_q;

    assign oDbg.state     = state_q;
    assign oDbg.pos_x     = pos_x;
    assign oDbg.pos_y     = pos_y;
    assign oDbg.dir_x     = dir_x;
    assign oDbg.dir_y     = dir_y;
    assign oDbg.flash_cnt = flash_q;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Directed bench for vga_sprite_gen with default parameters
// (640x480 visible area, 32-pixel box, 8 flash frames).
module tb_vga_sprite_gen;
    import vga_pkg::*;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [9:0] iX = '0;
    logic [9:0] iY = '0;
    logic       iImValid = 1'b0;
    logic       iRun = 1'b0;
    logic [3:0] iSpeed = '0;
    logic [9:0] oRed, oGreen, oBlue;
    logic [7:0] oBounceCnt;
    dbg_t       oDbg;

    int errors = 0;
    int checks = 0;

    vga_sprite_gen dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iX         (iX),
        .iY         (iY),
        .iImValid   (iImValid),
        .iRun       (iRun),
        .iSpeed     (iSpeed),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oBounceCnt (oBounceCnt),
        .oDbg       (oDbg)
    );

    // 25 MHz pixel clock
    always #20 iClk = ~iClk;

    task automatic clk_step();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        iX       = 10'(x);
        iY       = 10'(y);
        iImValid = v;
    endtask

    // One frame tick (last visible pixel) with the given speed.
    task automatic tick(input int spd);
        iSpeed = 4'(spd);
        set_pix(639, 479, 1'b1);
        clk_step();
        set_pix(0, 0, 1'b0);
    endtask

    // Expected colour for a pixel given sprite position and hit state.
    function automatic rgb_t exp_col(input int x, input int y, input logic v,
                                     input int px, input int py, input logic hit);
        if (!v) return {10'd0, 10'd0, 10'd0};
        if (x >= px && x < px + 32 && y >= py && y < py + 32)
            return hit ? {10'd1023, 10'd0, 10'd0} : {10'd1023, 10'd1023, 10'd0};
        return {10'd0, 10'd0, 10'd512};
    endfunction

    task automatic test_reset();
        iRst = 1'b1;
        set_pix(5, 5, 1'b1);
        clk_step();
        clk_step();
        checks++;
        if ({oRed, oGreen, oBlue} !== 30'd0) begin
            errors++;
            $display("FAIL reset_colour: got %0d/%0d/%0d want 0/0/0", oRed, oGreen, oBlue);
        end
        checks++;
        if (oDbg.state !== ST_PAUSE || oDbg.pos_x !== 10'd0 || oDbg.pos_y !== 10'd0 ||
            oDbg.dir_x !== 1'b0 || oDbg.dir_y !== 1'b0 || oDbg.flash_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d pos=(%0d,%0d) dir=%0b%0b flash=%0d want st=0 pos=(0,0) dir=00 flash=0",
                     oDbg.state, oDbg.pos_x, oDbg.pos_y, oDbg.dir_x, oDbg.dir_y, oDbg.flash_cnt);
        end
        checks++;
        if (oBounceCnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", oBounceCnt);
        end
        iRst = 1'b0;
        set_pix(0, 0, 1'b0);
    endtask

    // Paused box at (0,0): sweep a few rows and check one-cycle latency.
    task automatic test_sweep();
        int   rows[5];
        rgb_t exp;
        rows = '{0, 31, 32, 100, 479};
        iRun = 1'b0;
        set_pix(0, 0, 1'b1);
        clk_step();
        exp = exp_col(0, 0, 1'b1, 0, 0, 1'b0);
        foreach (rows[r]) begin
            for (int x = 0; x < 66; x++) begin
                // Next pixel is applied before checking: the output must still
                // show the previous one.
                set_pix(x, rows[r], 1'b1);
                #1;
                checks++;
                if ({oRed, oGreen, oBlue} !== exp) begin
                    errors++;
                    $display("FAIL sweep_pixel: before (%0d,%0d) got %0d/%0d/%0d want %0d/%0d/%0d",
                             x, rows[r], oRed, oGreen, oBlue, exp.r, exp.g, exp.b);
                end
                clk_step();
                exp = exp_col(x, rows[r], 1'b1, 0, 0, 1'b0);
            end
        end
        // Blanking inside the box region gives black.
        set_pix(5, 5, 1'b0);
        clk_step();
        checks++;
        if ({oRed, oGreen, oBlue} !== 30'd0) begin
            errors++;
            $display("FAIL sweep_blank: got %0d/%0d/%0d want 0/0/0", oRed, oGreen, oBlue);
        end
    endtask

    // Speed 4 for 10 ticks, then speed changes without tick and pause.
    task automatic test_motion();
        rgb_t exp;
        int   px[4];
        int   py[4];
        test_reset();
        iRun = 1'b1;
        clk_step();
        for (int i = 0; i < 10; i++) tick(4);
        checks++;
        if (oDbg.pos_x !== 10'd40 || oDbg.pos_y !== 10'd40 || oBounceCnt !== 8'd0 ||
            oDbg.state !== ST_RUN) begin
            errors++;
            $display("FAIL motion_10: got pos=(%0d,%0d) cnt=%0d st=%0d want (40,40) cnt=0 st=1",
                     oDbg.pos_x, oDbg.pos_y, oBounceCnt, oDbg.state);
        end
        px = '{40, 39, 71, 72};
        py = '{40, 40, 71, 40};
        foreach (px[i]) begin
            set_pix(px[i], py[i], 1'b1);
            clk_step();
            exp = exp_col(px[i], py[i], 1'b1, 40, 40, 1'b0);
            checks++;
            if ({oRed, oGreen, oBlue} !== exp) begin
                errors++;
                $display("FAIL motion_pixel: (%0d,%0d) got %0d/%0d/%0d want %0d/%0d/%0d",
                         px[i], py[i], oRed, oGreen, oBlue, exp.r, exp.g, exp.b);
            end
        end
        // Speed is only sampled on a tick.
        iSpeed = 4'd15;
        set_pix(639, 478, 1'b1);
        clk_step();
        clk_step();
        checks++;
        if (oDbg.pos_x !== 10'd40 || oDbg.pos_y !== 10'd40) begin
            errors++;
            $display("FAIL motion_no_tick: got pos=(%0d,%0d) want (40,40)", oDbg.pos_x, oDbg.pos_y);
        end
        // Pause freezes the box.
        iRun = 1'b0;
        set_pix(0, 0, 1'b0);
        clk_step();
        checks++;
        if (oDbg.state !== ST_PAUSE) begin
            errors++;
            $display("FAIL pause_state: got %0d want 0", oDbg.state);
        end
        tick(15);
        checks++;
        if (oDbg.pos_x !== 10'd40 || oDbg.pos_y !== 10'd40) begin
            errors++;
            $display("FAIL pause_frozen: got pos=(%0d,%0d) want (40,40)", oDbg.pos_x, oDbg.pos_y);
        end
    endtask

    // Right-wall bounce from x=606 at speed 5, then the hit flash.
    // Speed 15 x40: x=600; y hits bottom on tick 30 (435+15>=448) and
    // returns to 298; HIT flash expires on tick 38.
    task automatic test_bounce();
        rgb_t exp;
        test_reset();
        iRun = 1'b1;
        clk_step();
        for (int i = 0; i < 40; i++) tick(15);
        checks++;
        if (oDbg.pos_x !== 10'd600 || oDbg.pos_y !== 10'd298 || oDbg.dir_y !== 1'b1 ||
            oBounceCnt !== 8'd1 || oDbg.state !== ST_RUN) begin
            errors++;
            $display("FAIL bounce_pre: got pos=(%0d,%0d) diry=%0b cnt=%0d st=%0d want (600,298) diry=1 cnt=1 st=1",
                     oDbg.pos_x, oDbg.pos_y, oDbg.dir_y, oBounceCnt, oDbg.state);
        end
        tick(3);
        tick(3);
        checks++;
        if (oDbg.pos_x !== 10'd606 || oDbg.pos_y !== 10'd292 || oDbg.dir_x !== 1'b0) begin
            errors++;
            $display("FAIL bounce_606: got pos=(%0d,%0d) dirx=%0b want (606,292) dirx=0",
                     oDbg.pos_x, oDbg.pos_y, oDbg.dir_x);
        end
        tick(5);
        checks++;
        if (oDbg.pos_x !== 10'd608 || oDbg.pos_y !== 10'd287 || oDbg.dir_x !== 1'b1 ||
            oDbg.state !== ST_HIT || oBounceCnt !== 8'd2 || oDbg.flash_cnt !== 8'd7) begin
            errors++;
            $display("FAIL bounce_hit: got pos=(%0d,%0d) dirx=%0b st=%0d cnt=%0d flash=%0d want (608,287) dirx=1 st=2 cnt=2 flash=7",
                     oDbg.pos_x, oDbg.pos_y, oDbg.dir_x, oDbg.state, oBounceCnt, oDbg.flash_cnt);
        end
        set_pix(608, 287, 1'b1);
        clk_step();
        exp = exp_col(608, 287, 1'b1, 608, 287, 1'b1);
        checks++;
        if ({oRed, oGreen, oBlue} !== exp) begin
            errors++;
            $display("FAIL bounce_red: got %0d/%0d/%0d want %0d/%0d/%0d", oRed, oGreen, oBlue, exp.r, exp.g, exp.b);
        end
        set_pix(607, 287, 1'b1);
        clk_step();
        exp = exp_col(607, 287, 1'b1, 608, 287, 1'b1);
        checks++;
        if ({oRed, oGreen, oBlue} !== exp) begin
            errors++;
            $display("FAIL bounce_edge: got %0d/%0d/%0d want %0d/%0d/%0d", oRed, oGreen, oBlue, exp.r, exp.g, exp.b);
        end
        // Seven more ticks keep HIT (flash 7 -> 0); the eighth returns to RUN.
        for (int i = 0; i < 7; i++) tick(0);
        set_pix(620, 300, 1'b1);
        clk_step();
        exp = exp_col(620, 300, 1'b1, 608, 287, 1'b1);
        checks++;
        if ({oRed, oGreen, oBlue} !== exp || oDbg.state !== ST_HIT || oDbg.flash_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flash_last: got %0d/%0d/%0d st=%0d flash=%0d want %0d/%0d/%0d st=2 flash=0",
                     oRed, oGreen, oBlue, oDbg.state, oDbg.flash_cnt, exp.r, exp.g, exp.b);
        end
        tick(0);
        set_pix(620, 300, 1'b1);
        clk_step();
        exp = exp_col(620, 300, 1'b1, 608, 287, 1'b0);
        checks++;
        if ({oRed, oGreen, oBlue} !== exp || oDbg.state !== ST_RUN) begin
            errors++;
            $display("FAIL flash_end: got %0d/%0d/%0d st=%0d want %0d/%0d/%0d st=1",
                     oRed, oGreen, oBlue, oDbg.state, exp.r, exp.g, exp.b);
        end
    endtask

    // Speed 8 from reset: x bounces at ticks t%153==76 (right) and
    // t%153==0 (left, after one tick resting at 0); y at t%113==56 and
    // t%113==0. Tick 8644 hits both right and bottom walls together.
    task automatic test_corner_wrap();
        int   exp_total;
        logic hit, cornered, wrapped;
        exp_total = 0;
        cornered  = 1'b0;
        wrapped   = 1'b0;
        test_reset();
        iRun = 1'b1;
        clk_step();
        for (int t = 1; t <= 20000 && !(cornered && wrapped); t++) begin
            hit = (t % 153 == 76) || (t % 153 == 0) || (t % 113 == 56) || (t % 113 == 0);
            if (t == 8644) begin
                checks++;
                if (oDbg.pos_x !== 10'd600 || oDbg.pos_y !== 10'd440 || oBounceCnt !== 8'(exp_total)) begin
                    errors++;
                    $display("FAIL corner_pre: got pos=(%0d,%0d) cnt=%0d want (600,440) cnt=%0d",
                             oDbg.pos_x, oDbg.pos_y, oBounceCnt, exp_total % 256);
                end
            end
            tick(8);
            if (hit) exp_total++;
            if (t == 8644) begin
                cornered = 1'b1;
                checks++;
                if (oDbg.pos_x !== 10'd608 || oDbg.pos_y !== 10'd448 || oDbg.dir_x !== 1'b1 ||
                    oDbg.dir_y !== 1'b1 || oDbg.state !== ST_HIT || oBounceCnt !== 8'(exp_total)) begin
                    errors++;
                    $display("FAIL corner_hit: got pos=(%0d,%0d) dir=%0b%0b st=%0d cnt=%0d want (608,448) dir=11 st=2 cnt=%0d",
                             oDbg.pos_x, oDbg.pos_y, oDbg.dir_x, oDbg.dir_y, oDbg.state, oBounceCnt, exp_total % 256);
                end
            end
            if (hit && exp_total == 255) begin
                checks++;
                if (oBounceCnt !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: got %0d want 255 at tick %0d", oBounceCnt, t);
                end
            end
            if (hit && exp_total == 256) begin
                wrapped = 1'b1;
                checks++;
                if (oBounceCnt !== 8'd0) begin
                    errors++;
                    $display("FAIL count_wrap: got %0d want 0 at tick %0d", oBounceCnt, t);
                end
            end
        end
        checks++;
        if (!(cornered && wrapped)) begin
            errors++;
            $display("FAIL corner_budget: got cornered=%0b wrapped=%0b want 1/1", cornered, wrapped);
        end
    endtask

    // Reset mid-frame on line 200, and reset coinciding with a frame tick.
    task automatic test_mid_reset();
        for (int x = 100; x < 104; x++) begin
            set_pix(x, 200, 1'b1);
            clk_step();
        end
        iRst = 1'b1;
        set_pix(104, 200, 1'b1);
        clk_step();
        iRst = 1'b0;
        checks++;
        if ({oRed, oGreen, oBlue} !== 30'd0 || oDbg.state !== ST_PAUSE ||
            oDbg.pos_x !== 10'd0 || oDbg.pos_y !== 10'd0 || oBounceCnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got %0d/%0d/%0d st=%0d pos=(%0d,%0d) cnt=%0d want 0/0/0 st=0 (0,0) cnt=0",
                     oRed, oGreen, oBlue, oDbg.state, oDbg.pos_x, oDbg.pos_y, oBounceCnt);
        end
        iRun = 1'b1;
        set_pix(0, 0, 1'b0);
        clk_step();
        tick(5);
        tick(5);
        checks++;
        if (oDbg.pos_x !== 10'd10 || oDbg.pos_y !== 10'd10) begin
            errors++;
            $display("FAIL pre_tick_reset: got pos=(%0d,%0d) want (10,10)", oDbg.pos_x, oDbg.pos_y);
        end
        iRst   = 1'b1;
        iSpeed = 4'd5;
        set_pix(639, 479, 1'b1);
        clk_step();
        iRst = 1'b0;
        set_pix(0, 0, 1'b0);
        checks++;
        if (oDbg.pos_x !== 10'd0 || oDbg.pos_y !== 10'd0 || oDbg.state !== ST_PAUSE ||
            {oRed, oGreen, oBlue} !== 30'd0) begin
            errors++;
            $display("FAIL tick_reset: got pos=(%0d,%0d) st=%0d rgb=%0d/%0d/%0d want (0,0) st=0 0/0/0",
                     oDbg.pos_x, oDbg.pos_y, oDbg.state, oRed, oGreen, oBlue);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_motion();
        test_bounce();
        test_corner_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sprite_gen.md
VGA_SPRITE_GEN -- requirements
Module: vga_sprite_gen

Interface
REQ-001 Parameter BOX_SIZE, default 32, meaning side length of the square sprite in pixels (legal range 8..128).
REQ-002 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 Parameter FLASH_FRAMES, default 8, meaning frames the sprite shows the hit colour after a bounce.
REQ-005 Port iClk, input, 1, 25 MHz pixel clock; the block SHALL use one clock only, and that clock is iClk.
REQ-006 Port iRst, input, 1, reset; reset is synchronous and active-high.
REQ-007 Port iX, input, 10, current pixel column from the VGA controller.
REQ-008 Port iY, input, 10, current pixel row from the VGA controller.
REQ-009 Port iImValid, input, 1, high when (iX, iY) is in the visible area.
REQ-010 Port iRun, input, 1, high to animate the sprite; low to freeze it.
REQ-011 Port iSpeed, input, 4, pixels moved per frame on each axis; value 0 means no motion.
REQ-012 Port oRed, output, 10, red value for the VGA controller.
REQ-013 Port oGreen, output, 10, green value for the VGA controller.
REQ-014 Port oBlue, output, 10, blue value for the VGA controller.
REQ-015 Port oBounceCnt, output, 8, wall-hit count, suitable for driving the seven-segment number input.

Function
REQ-016 Colour outputs SHALL be registered with exactly 1 cycle latency from iX/iY/iImValid.
REQ-017 Colour selection:
- iImValid low: 0/0/0.
- Pixel inside the box (posX <= iX < posX+BOX_SIZE and posY <= iY < posY+BOX_SIZE), state RUN or PAUSE: 1023/1023/0.
- Pixel inside the box, state HIT: 1023/0/0.
- Otherwise background: 0/0/512.
REQ-018 A frame tick SHALL occur in the single cycle where iImValid=1, iX=H_ACTIVE-1 and iY=V_ACTIVE-1.
REQ-019 Position registers (posX, posY) SHALL change only on a frame tick, so the box is never torn within a frame.
REQ-020 Each axis SHALL move independently on a frame tick in RUN or HIT: new = pos ± iSpeed, computed at 11 bits so no wrap can occur.
REQ-021 Bounce rule for X (identical for Y with V_ACTIVE):
- Moving right and pos+iSpeed >= H_ACTIVE-BOX_SIZE: clamp pos to H_ACTIVE-BOX_SIZE and flip direction.
- Moving left and pos < iSpeed: clamp pos to 0 and flip direction.
REQ-022 Each frame tick with at least one axis bounce SHALL increment oBounceCnt by exactly 1 (a corner hit counts once); the count wraps 255→0.
REQ-023 State machine states are PAUSE, RUN and HIT.
REQ-024 State PAUSE: go to RUN when iRun=1.
REQ-025 State RUN:
- iRun=0: go to PAUSE.
- Bounce on a frame tick: go to HIT and load flashCnt=FLASH_FRAMES-1.
REQ-026 State HIT:
- Each frame tick decrements flashCnt.
- On a tick with flashCnt=0: go to RUN.
- A new bounce reloads flashCnt.
- iRun=0: go to PAUSE immediately.
REQ-027 iRun is sampled every cycle; a change to iRun takes effect on the next frame tick boundary for motion, and at the next clock edge for state.
REQ-028 iSpeed is sampled only on the frame tick.

Reset
REQ-029 iRst=1 SHALL, at the next iClk edge, set:
- state=PAUSE, posX=0, posY=0, direction right/down, flashCnt=0, oBounceCnt=0;
- colour outputs 0/0/0.
REQ-030 Reset asserted mid-frame SHALL take priority over all other updates, including a coincident frame tick.

Structure
REQ-031 The state enumeration and the colour constants (box, hit, background) SHALL live in the shared package vga_pkg.
REQ-032 The per-axis move-and-bounce logic SHALL be one sub-module, sprite_axis, instantiated twice (once with limit H_ACTIVE, once with limit V_ACTIVE).

Verification
REQ-033 Scenario: reset, iRun=0, sweep one frame → oRed=1023 exactly on pixels (0..31, 0..31), 1 cycle late; background 0/0/512 elsewhere.
REQ-034 Scenario: iRun=1, iSpeed=4, 10 frame ticks → posX=40, posY=40; oBounceCnt=0.
REQ-035 Scenario: posX=606, moving right, iSpeed=5 → posX=608, direction left, state HIT, oBounceCnt=1; box red for 8 frames, then yellow.
REQ-036 Scenario: force a corner hit (posX=608, posY=448) → oBounceCnt increments by 1 only.
REQ-037 Scenario: oBounceCnt=255 plus one bounce → 0.
REQ-038 Scenario: iRst pulsed during line 200 → next-cycle outputs 0/0/0, state PAUSE, position (0,0).
